// File: rtl/regalu_pkg.sv
// Shared definitions for the regalu_seq datapath: ALU opcodes, flag bit positions
// and the sequencing FSM state type.
package regalu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/regalu_alu.sv
// Combinational ALU for regalu_seq: add/sub, shifts, compares and bitwise ops,
// with zero, carry/borrow, signed-overflow and sign flags.
module regalu_alu
    import regalu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_out,
    output logic            o_zf,
    output logic            o_cf,
    output logic            o_of,
    output logic            o_sf
);
    localparam int SW = $clog2(XLEN);
    localparam int M  = XLEN - 1;

    logic [SW-1:0] w_sh;
    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_diff;
    logic [XLEN-1:0] w_out;
    logic w_cf;
    logic w_of;

    assign w_sh   = i_b[SW-1:0];
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // The extra top bit of the difference is the unsigned borrow (a < b).
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        w_out = '0;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_out = w_sum[XLEN-1:0];
                w_cf  = w_sum[XLEN];
                w_of  = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            OP_SUB: begin
                w_out = w_diff[XLEN-1:0];
                w_cf  = w_diff[XLEN];
                w_of  = (i_a[M] != i_b[M]) && (w_diff[M] != i_a[M]);
            end
            OP_SLL:  w_out = i_a << w_sh;
            OP_SRL:  w_out = i_a >> w_sh;
            OP_SRA:  w_out = $unsigned($signed(i_a) >>> w_sh);
            OP_SLT:  w_out = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: w_out = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            OP_XOR:  w_out = i_a ^ i_b;
            OP_OR:   w_out = i_a | i_b;
            OP_AND:  w_out = i_a & i_b;
            default: w_out = '0;
        endcase
    end

    assign o_out = w_out;
    assign o_zf  = (w_out == '0);
    assign o_sf  = w_out[M];
    assign o_cf  = w_cf;
    assign o_of  = w_of;

endmodule

// File: rtl/regalu_seq.sv
// Register file + ALU sequenced READ -> EXEC -> WB by a start/busy/done FSM.
// Define REGALU_B2B_EN to let WB accept the next command (3-cycle throughput).
module regalu_seq
    import regalu_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   r_addr_a,
    input  logic [AW-1:0]   r_addr_b,
    input  logic [AW-1:0]   w_addr,
    input  logic [3:0]      alu_op,
    input  logic            reg_write,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    state_t r_state;
    state_t w_state_next;
    logic   w_accept;

    logic [AW-1:0]   r_ra, r_rb, r_wa;
    logic [3:0]      r_op;
    logic            r_we;
    logic [XLEN-1:0] r_a, r_b;
    logic [XLEN-1:0] r_result;
    logic [3:0]      r_flags;
    logic            r_done;

    logic [XLEN-1:0] w_rf [NREG];
    logic            w_wb_en;
    logic [XLEN-1:0] w_alu_out;
    logic            w_zf, w_cf, w_of, w_sf;

    assign w_wb_en = (r_state == WB) && r_we && (r_wa != '0);

    // Entry 0 has no storage so it reads as zero and silently drops writes.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign w_rf[gi] = '0;
            end else begin : g_entry
                logic [XLEN-1:0] r_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (w_wb_en && (r_wa == AW'(gi))) begin
                        r_q <= r_result;
                    end
                end
                assign w_rf[gi] = r_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = READ;
                end
            end
            READ: w_state_next = EXEC;
            EXEC: w_state_next = WB;
            WB: begin
`ifdef REGALU_B2B_EN
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = READ;
                end else begin
                    w_state_next = IDLE;
                end
`else
                w_state_next = IDLE;
`endif
            end
            default: w_state_next = IDLE;
        endcase
    end

    regalu_alu #(.XLEN(XLEN)) u_alu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_op  (r_op),
        .o_out (w_alu_out),
        .o_zf  (w_zf),
        .o_cf  (w_cf),
        .o_of  (w_of),
        .o_sf  (w_sf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra     <= '0;
            r_rb     <= '0;
            r_wa     <= '0;
            r_op     <= '0;
            r_we     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == WB);
            if (w_accept) begin
                r_ra <= r_addr_a;
                r_rb <= r_addr_b;
                r_wa <= w_addr;
                r_op <= alu_op;
                r_we <= reg_write;
            end
            // A command accepted in WB reads one edge after the write lands, so no bypass.
            if (r_state == READ) begin
                r_a <= w_rf[r_ra];
                r_b <= w_rf[r_rb];
            end
            if (r_state == EXEC) begin
                r_result         <= w_alu_out;
                r_flags[FLAG_ZF] <= w_zf;
                r_flags[FLAG_CF] <= w_cf;
                r_flags[FLAG_OF] <= w_of;
                r_flags[FLAG_SF] <= w_sf;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign result   = r_result;
    assign flags    = r_flags;
    assign dbg_data = w_rf[dbg_addr];

endmodule
